// File: rtl/chip8_pkg.sv
// Shared CHIP-8 fetch definitions: widths, reset vector, fetch FSM states.
// The return stack is compiled in only when CHIP8_FETCH_STACK_EN is defined.
package chip8_pkg;

    localparam int ADDR_W   = 12;
    localparam int OPCODE_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 12'h200;

    typedef enum logic [1:0] {
        FETCH_HI = 2'd0,
        FETCH_LO = 2'd1,
        CAPTURE  = 2'd2,
        READY    = 2'd3
    } fetch_state_e;

    // Program addresses wrap at the top of the 4 KiB space.
    function automatic logic [ADDR_W-1:0] pc_add(
        input logic [ADDR_W-1:0] a,
        input logic [2:0]        n
    );
        return a + ADDR_W'(n);
    endfunction

endpackage

// File: rtl/call_stack.sv
// LIFO of return addresses for the fetch unit.
// DEPTH must be a power of two; push when full and pop when empty are ignored.
import chip8_pkg::*;

module call_stack #(
    parameter int DEPTH = 16,
    parameter int W     = ADDR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] sp;

    assign full     = (sp == PW'(DEPTH));
    assign empty    = (sp == '0);
    assign top_data = mem[IW'(sp - PW'(1))];

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + PW'(1);
        end else if (pop && !empty) begin
            sp <= sp - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[IW'(sp)] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// CHIP-8 instruction fetch: two byte reads per opcode, PC sequencing, jumps.
// Define CHIP8_FETCH_STACK_EN to build in the call/return stack.
import chip8_pkg::*;

module instr_fetch #(
    parameter logic [ADDR_W-1:0] RESET_PC    = RESET_PC_DEF,
    parameter int                STACK_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd,
    input  logic [7:0]          mem_rdata,
    output logic [OPCODE_W-1:0] opcode,
    output logic                opcode_valid,
    input  logic                next,
    input  logic                pc_load,
    input  logic [ADDR_W-1:0]   pc_target,
    input  logic                skip,
    input  logic                call,
    input  logic                ret,
    output logic [ADDR_W-1:0]   pc,
    output logic                stack_err
);

    fetch_state_e          state_q;
    logic [ADDR_W-1:0]     pc_q;
    logic [ADDR_W-1:0]     next_pc;
    logic [ADDR_W-1:0]     ret_addr;
    logic [OPCODE_W-1:0]   op_q;
    logic                  advance;
    logic                  jump;
    logic                  ret_ok;

    assign advance      = (state_q == READY) && next;
    assign jump         = call || pc_load;
    assign pc           = pc_q;
    assign opcode       = op_q;
    assign opcode_valid = (state_q == READY);

`ifdef CHIP8_FETCH_STACK_EN
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              err_q;
    logic [ADDR_W-1:0] top;

    assign push     = advance && call && !full;
    assign pop      = advance && !jump && ret && !empty;
    assign ret_ok   = !empty;
    assign ret_addr = top;

    call_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_add(pc_q, 3'd2)),
        .top_data  (top),
        .full      (full),
        .empty     (empty)
    );

    // Overflowing call still jumps; underflowing ret falls through to pc+2.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (advance && ((call && full) || (!jump && ret && empty))) begin
            err_q <= 1'b1;
        end
    end

    assign stack_err = err_q;
`else
    logic unused_cfg;

    assign ret_ok     = 1'b0;
    assign ret_addr   = '0;
    assign stack_err  = 1'b0;
    assign unused_cfg = STACK_DEPTH[0];
`endif

    always_comb begin
        next_pc = pc_add(pc_q, 3'd2);
        if (jump) begin
            next_pc = pc_target;
        end else if (ret) begin
            next_pc = ret_ok ? ret_addr : pc_add(pc_q, 3'd2);
        end else if (skip) begin
            next_pc = pc_add(pc_q, 3'd4);
        end
    end

    always_comb begin
        mem_addr = pc_q;
        mem_rd   = 1'b0;
        unique case (state_q)
            FETCH_HI: mem_rd = !reset;
            FETCH_LO: begin
                mem_addr = pc_add(pc_q, 3'd1);
                mem_rd   = !reset;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH_HI;
            pc_q    <= RESET_PC;
            op_q    <= '0;
        end else begin
            unique case (state_q)
                FETCH_HI: state_q <= FETCH_LO;
                FETCH_LO: begin
                    op_q[15:8] <= mem_rdata;
                    state_q    <= CAPTURE;
                end
                CAPTURE: begin
                    op_q[7:0] <= mem_rdata;
                    state_q   <= READY;
                end
                READY: begin
                    if (next) begin
                        pc_q    <= next_pc;
                        state_q <= FETCH_HI;
                    end
                end
                default: state_q <= FETCH_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed corner cases plus random
// control sequences against an instruction-level reference model.
module tb_instr_fetch;

`ifdef CHIP8_FETCH_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] opcode;
    logic        opcode_valid;
    logic        next = 1'b0;
    logic        pc_load = 1'b0;
    logic [11:0] pc_target = 12'h000;
    logic        skip = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [11:0] pc;
    logic        stack_err;

    instr_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_rdata    (mem_rdata),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .next         (next),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .skip         (skip),
        .call         (call),
        .ret          (ret),
        .pc           (pc),
        .stack_err    (stack_err)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [4096];

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    int total = 0;
    int bad = 0;
    int m_pc;
    int stk[$];
    bit m_err;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_op();
        return {ram[m_pc], ram[(m_pc + 1) % 4096]};
    endfunction

    task automatic drop_ctrl();
        next = 1'b0;
        pc_load = 1'b0;
        skip = 1'b0;
        call = 1'b0;
        ret = 1'b0;
    endtask

    task automatic wait_ready(input int exp_lat, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!opcode_valid && n < 20);
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_op"}, opcode, exp_op());
        check({tag, "_rd"}, mem_rd, 1'b0);
        check({tag, "_err"}, stack_err, m_err);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drop_ctrl();
        repeat (3) @(negedge clk);
        check("rst_valid", opcode_valid, 1'b0);
        check("rst_rd", mem_rd, 1'b0);
        check("rst_pc", pc, 12'h200);
        check("rst_op", opcode, 16'h0000);
        check("rst_err", stack_err, 1'b0);
        m_pc = 12'h200;
        stk.delete();
        m_err = 1'b0;
        reset = 1'b0;
        wait_ready(3, "boot");
    endtask

    // Instruction-level model: where the PC goes after one completed opcode.
    task automatic model_advance(input logic ld, input logic sk,
                                 input logic cl, input logic rt,
                                 input logic [11:0] tgt);
        int np;
        if (cl || ld) begin
            if (STACK_EN && cl) begin
                if (stk.size() >= 16) m_err = 1'b1;
                else stk.push_back((m_pc + 2) % 4096);
            end
            np = int'(tgt);
        end else if (rt) begin
            if (STACK_EN && stk.size() > 0) begin
                np = stk.pop_back();
            end else begin
                if (STACK_EN) m_err = 1'b1;
                np = (m_pc + 2) % 4096;
            end
        end else if (sk) begin
            np = (m_pc + 4) % 4096;
        end else begin
            np = (m_pc + 2) % 4096;
        end
        m_pc = np;
    endtask

    task automatic step(input logic ld, input logic sk, input logic cl,
                        input logic rt, input logic [11:0] tgt,
                        input string tag);
        logic [15:0] old;
        old = opcode;
        next = 1'b1;
        pc_load = ld;
        skip = sk;
        call = cl;
        ret = rt;
        pc_target = tgt;
        model_advance(ld, sk, cl, rt, tgt);
        @(negedge clk);
        drop_ctrl();
        check({tag, "_drop"}, opcode_valid, 1'b0);
        check({tag, "_hold"}, opcode, old);
        wait_ready(3, tag);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        ram[12'h200] = 8'h12;
        ram[12'h201] = 8'h34;

        do_reset();
        check("boot_const", opcode, 16'h1234);

        step(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, "skip");
        check("skip_const", pc, 12'h204);
        step(1'b1, 1'b0, 1'b0, 1'b0, 12'h3A0, "jump");
        check("jump_const", pc, 12'h3A0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF, "top");
        check("top_op", opcode, {ram[12'hFFF], ram[12'h000]});
        step(1'b1, 1'b0, 1'b0, 1'b0, 12'hFFE, "pre_wrap");
        step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, "wrap");
        check("wrap_const", pc, 12'h000);

        // next and a jump held through the fetch must not move the PC.
        next = 1'b1;
        model_advance(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        @(negedge clk);
        check("hold_drop", opcode_valid, 1'b0);
        pc_load = 1'b1;
        pc_target = 12'h555;
        @(negedge clk);
        check("hold_pc1", pc, m_pc);
        @(negedge clk);
        check("hold_pc2", pc, m_pc);
        drop_ctrl();
        wait_ready(1, "hold");

`ifdef CHIP8_FETCH_STACK_EN
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, "ret_empty");
        check("ret_empty_err", stack_err, 1'b1);
        check("ret_empty_pc", pc, 12'h202);
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 12'h300, "call");
        check("call_pc", pc, 12'h300);
        step(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, "ret");
        check("ret_pc", pc, 12'h202);
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 12'($urandom), "nest");
        check("nest16_err", stack_err, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 12'h456, "nest17");
        check("nest17_err", stack_err, 1'b1);
        check("nest17_pc", pc, 12'h456);
`endif

        do_reset();
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                 12'($urandom), "rnd");
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                check("rnd_idle", opcode_valid, 1'b1);
            end
        end

        // Reset landing in FETCH_LO abandons the fetch.
        next = 1'b1;
        @(negedge clk);
        drop_ctrl();
        @(negedge clk);
        do_reset();
        check("midrst_op", opcode, 16'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h200, giving the PC value loaded at reset.
REQ-002 SHALL have parameter STACK_DEPTH, default 16, giving the number of return-stack entries.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mem_addr, output, 12 bits: byte address to program RAM.
REQ-006 SHALL have port mem_rd, output, 1 bit: read strobe.
REQ-007 SHALL have port mem_rdata, input, 8 bits: RAM data, valid one cycle after mem_rd.
REQ-008 SHALL have port opcode, output, 16 bits: assembled instruction to the decoder.
REQ-009 SHALL have port opcode_valid, output, 1 bit: opcode is stable and usable.
REQ-010 SHALL have port next, input, 1 bit: consumer has finished the instruction; advance.
REQ-011 SHALL have port pc_load, input, 1 bit, and port pc_target, input, 12 bits: jump request and its target.
REQ-012 SHALL have port skip, input, 1 bit: skip the following instruction.
REQ-013 SHALL have ports call and ret, inputs, 1 bit each: subroutine call to pc_target, and return.
REQ-014 SHALL have port pc, output, 12 bits: address of the current opcode.
REQ-015 SHALL have port stack_err, output, 1 bit: sticky stack overflow/underflow flag.

Function
REQ-016 SHALL implement FSM FETCH_HI -> FETCH_LO -> CAPTURE -> READY -> FETCH_HI.
REQ-017 FETCH_HI SHALL drive mem_addr=pc and mem_rd=1.
REQ-018 FETCH_LO SHALL latch mem_rdata into opcode[15:8], then drive mem_addr=pc+1 and mem_rd=1.
REQ-019 CAPTURE SHALL latch mem_rdata into opcode[7:0] with mem_rd=0; opcode_valid SHALL rise 3 cycles after FETCH_HI entry.
REQ-020 READY SHALL hold opcode and opcode_valid=1 until next=1; mem_rd SHALL be 0.
REQ-021 pc_load/skip/call/ret SHALL be sampled only in the cycle READY and next=1; otherwise ignored.
REQ-022 Next-PC priority on advance: call or pc_load -> pc_target; else ret -> popped address; else skip -> pc+4; else pc+2.
REQ-023 All PC arithmetic SHALL be modulo 4096 (pc+1, pc+2, pc+4 wrap at 0xFFF).
REQ-024 opcode_valid SHALL drop to 0 in the cycle after advance; opcode SHALL keep its old value until CAPTURE.
REQ-025 call SHALL push pc+2 (mod 4096); push when full SHALL set stack_err, discard the push and still jump.
REQ-026 ret on empty stack SHALL set stack_err and advance to pc+2.

Reset
REQ-027 Reset SHALL set pc=RESET_PC, state=FETCH_HI, opcode=16'h0000, opcode_valid=0, stack pointer=0, stack_err=0.
REQ-028 Reset asserted mid-fetch SHALL abandon the fetch; the first fetch after release SHALL read RESET_PC.
REQ-029 mem_rd SHALL be 0 while reset is high.

Configuration
REQ-030 Macro CHIP8_FETCH_STACK_EN defined SHALL compile in the return stack per REQ-022/025/026.
REQ-031 Without CHIP8_FETCH_STACK_EN: call SHALL act as pc_load, ret SHALL act as a plain advance (pc+2), stack_err SHALL be tied 0.

Structure
REQ-032 Shared package chip8_pkg SHALL hold ADDR_W=12, OPCODE_W=16, default RESET_PC 12'h200 and the fetch-state enum.
REQ-033 Return stack SHALL be a sub-module call_stack (push/pop/full/empty, STACK_DEPTH x 12 bits), instantiated only under CHIP8_FETCH_STACK_EN.

Verification
REQ-034 RAM 0x200=0x12,0x201=0x34, reset release -> opcode=16'h1234, opcode_valid high 3 cycles after first FETCH_HI, pc=0x200.
REQ-035 next with pc_load=1, pc_target=0x3A0 -> next fetch from 0x3A0/0x3A1; next with skip=1 at pc 0x200 -> pc=0x204.
REQ-036 pc=0xFFF fetch -> low byte read from 0x000; plain advance from 0xFFE -> pc=0x000.
REQ-037 call 0x300 at pc 0x200, then ret -> pc=0x202; 17 nested calls -> stack_err=1; ret on empty -> stack_err=1, pc+2.
REQ-038 reset asserted during FETCH_LO -> opcode_valid=0, next fetch at RESET_PC; next held high outside READY -> no PC change.
